// File: rtl/cp0_ext_if.sv
// Pipeline-side bus of the CP0 block: MFC0/MTC0 access, exception entry/ERET, and exported state.
// Strobes are single-cycle levels sampled on the rising edge; r_data is combinational.
interface cp0_ext_if;
    logic        r_ena;
    logic [7:0]  r_addr;
    logic [31:0] r_data;
    logic        w_ena;
    logic [7:0]  w_addr;
    logic [31:0] w_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_epc;
    logic        exc_badvaddr_ena;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] status;
    logic        int_req;

    modport master (
        output r_ena, r_addr, w_ena, w_addr, w_data,
               exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_ena, exc_badvaddr, eret,
        input  r_data, epc, status, int_req
    );

    modport slave (
        input  r_ena, r_addr, w_ena, w_addr, w_data,
               exc_valid, exc_code, exc_bd, exc_epc, exc_badvaddr_ena, exc_badvaddr, eret,
        output r_data, epc, status, int_req
    );
endinterface

// File: rtl/cp0_ext.sv
// MIPS-style CP0 register block: Count/Compare timer with prescaler, synchronised hardware
// interrupts, nested-exception EPC protection, ERET and a registered interrupt request.
module cp0_ext #(
    parameter int          COUNT_DIV   = 2,
    parameter int          HW_IRQ      = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID        = 32'h0000_4220
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HW_IRQ-1:0] hw_int,
    cp0_ext_if.slave          bus
);
    localparam logic [7:0] A_BADVADDR = 8'd64;
    localparam logic [7:0] A_COUNT    = 8'd72;
    localparam logic [7:0] A_COMPARE  = 8'd88;
    localparam logic [7:0] A_STATUS   = 8'd96;
    localparam logic [7:0] A_CAUSE    = 8'd104;
    localparam logic [7:0] A_EPC      = 8'd112;
    localparam logic [7:0] A_PRID     = 8'd120;
    localparam logic [7:0] A_CONFIG   = 8'd128;

    logic [31:0]       count_q, compare_q, epc_q, badvaddr_q;
    logic [7:0]        presc_q, im_q;
    logic              exl_q, ie_q, ti_q, bd_q, int_req_q;
    logic [4:0]        exc_code_q;
    logic [1:0]        sw_ip_q;
    logic [HW_IRQ-1:0] hw_ip_q, hw_s;
    logic [5:0]        hw6;
    logic [7:0]        ip;
    logic [31:0]       status_val, cause_val;
    logic [31:0]       rd_cur, rd_mask, r_data_c;
    logic              tick, wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    // Synchroniser chain; with zero stages the IP register itself samples the raw lines.
    if (SYNC_STAGES == 0) begin : g_nosync
        assign hw_s = hw_int;
    end else begin : g_sync
        logic [HW_IRQ-1:0] sync_q [SYNC_STAGES];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            end else begin
                sync_q[0] <= hw_int;
                for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            end
        end
        assign hw_s = sync_q[SYNC_STAGES-1];
    end

    assign hw6        = 6'(hw_ip_q);
    assign ip         = {ti_q | hw6[5], hw6[4:0], sw_ip_q};
    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

    assign tick       = (presc_q == 8'(COUNT_DIV - 1));
    assign wr_count   = bus.w_ena && (bus.w_addr == A_COUNT);
    assign wr_compare = bus.w_ena && (bus.w_addr == A_COMPARE);
    assign wr_status  = bus.w_ena && (bus.w_addr == A_STATUS);
    assign wr_cause   = bus.w_ena && (bus.w_addr == A_CAUSE);
    assign wr_epc     = bus.w_ena && (bus.w_addr == A_EPC);

    // A Count write restarts the prescaler and swallows the tick, so no timer match that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            presc_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= bus.w_data;
                presc_q <= '0;
            end else begin
                presc_q <= tick ? 8'd0 : presc_q + 8'd1;
                if (tick) count_q <= count_q + 32'd1;
            end
            if (wr_compare) begin
                compare_q <= bus.w_data;
                ti_q      <= 1'b0;
            end else if (tick && !wr_count && (count_q + 32'd1 == compare_q)) begin
                ti_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            sw_ip_q    <= '0;
            hw_ip_q    <= '0;
            int_req_q  <= 1'b0;
        end else begin
            if (wr_status) begin
                im_q <= bus.w_data[15:8];
                ie_q <= bus.w_data[0];
            end
            if (bus.exc_valid)     exl_q <= 1'b1;
            else if (bus.eret)     exl_q <= 1'b0;
            else if (wr_status)    exl_q <= bus.w_data[1];
            if (wr_cause) sw_ip_q <= bus.w_data[9:8];
            if (bus.exc_valid) begin
                exc_code_q <= bus.exc_code;
                if (!exl_q) bd_q <= bus.exc_bd;
            end
            hw_ip_q   <= hw_s;
            int_req_q <= ie_q & ~exl_q & (|(im_q & ip));
        end
    end

    // EPC is frozen while a handler is already running (EXL=1) so the first restart PC survives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus.exc_valid) begin
                if (!exl_q) epc_q <= bus.exc_epc;
            end else if (wr_epc) begin
                epc_q <= bus.w_data;
            end
            if (bus.exc_valid && bus.exc_badvaddr_ena) badvaddr_q <= bus.exc_badvaddr;
        end
    end

    always_comb begin
        rd_cur  = '0;
        rd_mask = '0;
        case (bus.r_addr)
            A_BADVADDR: rd_cur = badvaddr_q;
            A_COUNT:    begin rd_cur = count_q;    rd_mask = 32'hFFFF_FFFF; end
            A_COMPARE:  begin rd_cur = compare_q;  rd_mask = 32'hFFFF_FFFF; end
            A_STATUS:   begin rd_cur = status_val; rd_mask = 32'h0000_FF03; end
            A_CAUSE:    begin rd_cur = cause_val;  rd_mask = 32'h0000_0300; end
            A_EPC:      begin rd_cur = epc_q;      rd_mask = 32'hFFFF_FFFF; end
            A_PRID:     rd_cur = PRID;
            A_CONFIG:   rd_cur = 32'h8000_0000;
            default:    rd_cur = '0;
        endcase
        if (rst || !bus.r_ena)
            r_data_c = '0;
        else if (bus.w_ena && (bus.w_addr == bus.r_addr))
            r_data_c = (rd_cur & ~rd_mask) | (bus.w_data & rd_mask);
        else
            r_data_c = rd_cur;
    end

    assign bus.r_data  = r_data_c;
    assign bus.epc     = epc_q;
    assign bus.status  = status_val;
    assign bus.int_req = int_req_q;
endmodule

// File: tb/tb_cp0_ext.sv
// Randomised scoreboard bench for cp0_ext: reads push expectations from a spec-level model,
// a negedge monitor pops and compares whenever a read is presented.
module tb_cp0_ext;
  localparam int          COUNT_DIV   = 2;
  localparam int          HW_IRQ      = 6;
  localparam int          SYNC_STAGES = 2;
  localparam logic [31:0] PRID        = 32'h0000_4220;

  localparam logic [7:0] A_BVA = 8'd64, A_COUNT = 8'd72, A_COMPARE = 8'd88, A_STATUS = 8'd96;
  localparam logic [7:0] A_CAUSE = 8'd104, A_EPC = 8'd112, A_PRID = 8'd120, A_CONFIG = 8'd128;
  localparam logic [7:0] A_UNUSED = 8'd80;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [HW_IRQ-1:0] hw_int = '0;

  cp0_ext_if bus();

  cp0_ext #(.COUNT_DIV(COUNT_DIV), .HW_IRQ(HW_IRQ), .SYNC_STAGES(SYNC_STAGES), .PRID(PRID)) dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_st_q[$];
  logic        exp_irq_q[$];
  logic [7:0]  exp_addr_q[$];

  // ---------------- reference model ----------------
  logic [31:0] m_count, m_compare, m_epc, m_bva;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_ti, m_bd, m_int_req;
  logic        m_epc_ok = 1'b0;
  logic [4:0]  m_exc;
  logic [1:0]  m_swip;
  int          m_presc;
  logic [5:0]  m_hist [SYNC_STAGES+1];

  function automatic logic [7:0] m_ip();
    logic [5:0] h;
    h = m_hist[SYNC_STAGES];
    return {m_ti | h[5], h[4:0], m_swip};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
  endfunction

  function automatic logic [31:0] m_reg(input logic [7:0] a);
    case (a)
      A_BVA:     return m_bva;
      A_COUNT:   return m_count;
      A_COMPARE: return m_compare;
      A_STATUS:  return m_status();
      A_CAUSE:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_exc) << 2);
      A_EPC:     return m_epc;
      A_PRID:    return PRID;
      A_CONFIG:  return 32'h8000_0000;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] wmask(input logic [7:0] a);
    case (a)
      A_COUNT, A_COMPARE, A_EPC: return 32'hFFFF_FFFF;
      A_STATUS:                  return 32'h0000_FF03;
      A_CAUSE:                   return 32'h0000_0300;
      default:                   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] cur, msk;
    cur = m_reg(a);
    msk = wmask(a);
    if (rst) return 32'h0;
    if (bus.w_ena && bus.w_addr == a) return (cur & ~msk) | (bus.w_data & msk);
    return cur;
  endfunction

  always @(posedge clk) begin : model_step
    logic irq, old_exl, tick, ti_set;
    irq = m_ie && !m_exl && ((m_im & m_ip()) != 8'h0);
    if (rst) begin
      m_count = 0; m_compare = 0; m_im = 0; m_exl = 0; m_ie = 0; m_ti = 0;
      m_bd = 0; m_exc = 0; m_swip = 0; m_presc = 0; m_int_req = 0;
      for (int k = 0; k <= SYNC_STAGES; k++) m_hist[k] = '0;
    end else begin
      old_exl = m_exl;
      tick    = (m_presc == COUNT_DIV - 1);
      ti_set  = 1'b0;
      if (bus.w_ena && bus.w_addr == A_COUNT) begin
        m_count = bus.w_data;
        m_presc = 0;
      end else begin
        if (tick) begin
          ti_set  = (m_count + 32'd1 == m_compare);
          m_count = m_count + 32'd1;
        end
        m_presc = tick ? 0 : m_presc + 1;
      end
      if (bus.w_ena && bus.w_addr == A_COMPARE) begin
        m_compare = bus.w_data;
        m_ti = 1'b0;
      end else if (ti_set) m_ti = 1'b1;
      if (bus.w_ena && bus.w_addr == A_STATUS) begin
        m_im = bus.w_data[15:8]; m_ie = bus.w_data[0]; m_exl = bus.w_data[1];
      end
      if (bus.eret) m_exl = 1'b0;
      if (bus.w_ena && bus.w_addr == A_CAUSE) m_swip = bus.w_data[9:8];
      if (bus.w_ena && bus.w_addr == A_EPC && !bus.exc_valid) begin
        m_epc = bus.w_data; m_epc_ok = 1'b1;
      end
      if (bus.exc_valid) begin
        m_exl = 1'b1;
        m_exc = bus.exc_code;
        if (!old_exl) begin m_epc = bus.exc_epc; m_bd = bus.exc_bd; m_epc_ok = 1'b1; end
        if (bus.exc_badvaddr_ena) m_bva = bus.exc_badvaddr;
      end
      for (int k = SYNC_STAGES; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = 6'(hw_int);
      m_int_req = irq;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check32(input string name, input logic [7:0] a, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s addr=%02h got=%08h exp=%08h t=%0t", name, a, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (bus.r_ena) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow got=empty exp=entry t=%0t", $time);
      end else begin
        logic [7:0] a;
        logic       ei;
        a  = exp_addr_q.pop_front();
        ei = exp_irq_q.pop_front();
        check32("r_data", a, bus.r_data, exp_q.pop_front());
        check32("status", a, bus.status, exp_st_q.pop_front());
        check32("int_req", a, 32'(bus.int_req), 32'(ei));
        if (m_epc_ok) check32("epc_out", a, bus.epc, m_epc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(posedge clk);
    #1;
    bus.r_ena = 1'b0; bus.w_ena = 1'b0; bus.exc_valid = 1'b0; bus.eret = 1'b0;
    bus.exc_badvaddr_ena = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    bus.r_ena  = 1'b1;
    bus.r_addr = a;
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
    exp_st_q.push_back(m_status());
    exp_irq_q.push_back(m_int_req);
  endtask

  task automatic rd(input logic [7:0] a);
    push(a, model_read(a));
  endtask

  task automatic rd_const(input logic [7:0] a, input logic [31:0] d);
    push(a, d);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.w_ena = 1'b1; bus.w_addr = a; bus.w_data = d;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                     input logic bv_ena, input logic [31:0] bv);
    bus.exc_valid = 1'b1; bus.exc_code = code; bus.exc_epc = pc; bus.exc_bd = bd;
    bus.exc_badvaddr_ena = bv_ena; bus.exc_badvaddr = bv;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] addr_list [10];

  initial begin
    addr_list = '{A_BVA, A_COUNT, A_COMPARE, A_STATUS, A_CAUSE, A_EPC, A_PRID, A_CONFIG, A_UNUSED, 8'd73};
    bus.r_ena = 0; bus.r_addr = 0; bus.w_ena = 0; bus.w_addr = 0; bus.w_data = 0;
    bus.exc_valid = 0; bus.exc_code = 0; bus.exc_bd = 0; bus.exc_epc = 0;
    bus.exc_badvaddr_ena = 0; bus.exc_badvaddr = 0; bus.eret = 0;
    rst = 1'b1;
    repeat (3) idle();
    rst = 1'b0;

    rd_const(A_STATUS, 32'h0040_0000); idle();
    rd_const(A_CAUSE, 32'h0); idle();
    rd(A_COUNT); idle();

    // forwarding and read-only / unmapped addresses
    wr(A_STATUS, 32'hFFFF_FFFF); rd_const(A_STATUS, 32'h0040_FF03); idle();
    rd_const(A_STATUS, 32'h0040_FF03); idle();
    rd_const(A_PRID, PRID); idle();
    rd_const(A_UNUSED, 32'h0); idle();
    rd_const(A_CONFIG, 32'h8000_0000); idle();
    wr(A_PRID, 32'h1234_5678); rd_const(A_PRID, PRID); idle();

    // timer
    wr(A_STATUS, 32'h0000_8001); idle();
    wr(A_COUNT, 32'h0); idle();
    wr(A_COMPARE, 32'd5); idle();
    repeat (16) begin rd(A_CAUSE); idle(); end
    rd_const(A_CAUSE, 32'h4000_8000); idle();
    wr(A_COMPARE, 32'hFFFF_0000); rd(A_CAUSE); idle();
    rd_const(A_CAUSE, 32'h0); idle();
    rd(A_CAUSE); idle();

    // hardware interrupt line 0, enabled then masked
    wr(A_STATUS, 32'h0000_0401); hw_int = 6'b000001; idle();
    hw_int = '0;
    repeat (6) begin rd(A_CAUSE); idle(); end
    wr(A_STATUS, 32'h0000_0001); hw_int = 6'b000001; idle();
    hw_int = '0;
    repeat (6) begin rd(A_CAUSE); idle(); end

    // nested exceptions
    exc(5'd4, 32'h100, 1'b1, 1'b1, 32'hDEAD_BEEF); idle();
    exc(5'd5, 32'h200, 1'b0, 1'b0, 32'h0); idle();
    rd_const(A_EPC, 32'h100); idle();
    rd_const(A_CAUSE, 32'h8000_0014); idle();
    rd_const(A_BVA, 32'hDEAD_BEEF); idle();
    bus.eret = 1'b1; idle();
    rd(A_STATUS); idle();
    exc(5'd6, 32'h300, 1'b0, 1'b0, 32'h0); idle();
    rd_const(A_EPC, 32'h300); idle();

    // exception + ERET + MTC0 Status in one cycle
    exc(5'd7, 32'h400, 1'b0, 1'b0, 32'h0); bus.eret = 1'b1; wr(A_STATUS, 32'h0); idle();
    rd_const(A_STATUS, 32'h0040_0002); idle();
    rd_const(A_EPC, 32'h300); idle();
    bus.eret = 1'b1; idle();

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      if (i % 4 == 0) hw_int = 6'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r < 3) begin
        logic [7:0] a;
        a = addr_list[$urandom_range(0, 9)];
        if (a == A_COMPARE) wr(a, m_count + 32'($urandom_range(0, 12)));
        else if (a == A_STATUS) wr(a, $urandom() & 32'hFFFF_FF01);
        else wr(a, $urandom());
      end
      if ($urandom_range(0, 9) == 0) exc(5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 1)), $urandom());
      if ($urandom_range(0, 9) == 0) bus.eret = 1'b1;
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 4) != 0) rd(addr_list[$urandom_range(0, 9)]);
      idle();
      rst = 1'b0;
    end

    // reset in the middle of counting with TI set
    hw_int = '0;
    wr(A_STATUS, 32'h0000_8001); idle();
    wr(A_COUNT, 32'h0); idle();
    wr(A_COMPARE, 32'd3); idle();
    repeat (10) begin rd(A_CAUSE); idle(); end
    rst = 1'b1; rd_const(A_COUNT, 32'h0); idle();
    rst = 1'b0;
    rd_const(A_COUNT, 32'h0); idle();
    rd_const(A_CAUSE, 32'h0); idle();
    rd_const(A_STATUS, 32'h0040_0000); idle();
    rd(A_COUNT); idle();
    idle(); idle();

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
